// File: rtl/bip_datapath.sv
// bip_datapath: accumulator, add/sub ALU, operand sign extension and the
// data-memory request/acknowledge sequencer for the accumulator CPU.
// Optional build macro BIP_SAT_EN: saturate ALU results on signed overflow
// instead of wrapping.
//
// Memory handshake: a request (ram_re or ram_we) is raised on the edge that
// leaves IDLE and is held, together with ram_addr/ram_wdata, until the cycle
// in which ram_ack is high; the request drops on that edge. ram_ack is only
// meaningful in RD_WAIT/WR_WAIT and is ignored in IDLE.
module bip_datapath #(
    parameter int DATA_W       = 16,
    parameter int bits_address = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              SelA,
    input  logic                    SelB,
    input  logic                    WrAcc,
    input  logic                    Op,
    input  logic                    WrRam,
    input  logic                    RdRam,
    input  logic [bits_address-1:0] Operand,
    output logic [bits_address-1:0] ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    output logic                    ram_we,
    output logic                    ram_re,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic                    ram_ack,
    output logic                    stall,
    output logic [DATA_W-1:0]       Acc,
    output logic                    ovf,
    output logic [1:0]              dbgState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    // Controls captured when a read is issued; used on the ack cycle.
    logic [1:0] selALat;
    logic       selBLat;
    logic       opLat;
    logic       wrAccLat;

    // Controls actually steering the datapath this cycle.
    logic [1:0] selAEff;
    logic       selBEff;
    logic       opEff;
    logic       wrAccEn;

    logic [bits_address-1:0] immSrc;
    logic [DATA_W-1:0]       imm;
    logic [DATA_W-1:0]       memData;
    logic [DATA_W-1:0]       aluB;
    logic [DATA_W-1:0]       aluSum;
    logic [DATA_W-1:0]       aluRes;
    logic                    aluOvf;
    logic [DATA_W-1:0]       accNext;
    logic                    accWrite;

    assign dbgState = state;

    // Live controls in IDLE, latched controls while waiting on memory.
    always_comb begin
        selAEff = selALat;
        selBEff = selBLat;
        opEff   = opLat;
        wrAccEn = ram_ack && wrAccLat && (state == RD_WAIT);
        if (state == IDLE) begin
            selAEff = SelA;
            selBEff = SelB;
            opEff   = Op;
            wrAccEn = WrAcc && !RdRam && !WrRam;
        end
    end

    // Operand is not latched separately: ram_addr already holds it during a read.
    assign immSrc  = (state == IDLE) ? Operand : ram_addr;
    assign imm     = {{(DATA_W-bits_address){immSrc[bits_address-1]}}, immSrc};
    assign memData = (state == RD_WAIT && ram_ack) ? ram_rdata : '0;

    // ALU: add/sub with signed overflow detection and optional saturation.
    always_comb begin
        aluB   = selBEff ? imm : memData;
        aluSum = opEff ? (Acc - aluB) : (Acc + aluB);
        if (opEff) begin
            aluOvf = (Acc[DATA_W-1] != aluB[DATA_W-1]) && (aluSum[DATA_W-1] != Acc[DATA_W-1]);
        end else begin
            aluOvf = (Acc[DATA_W-1] == aluB[DATA_W-1]) && (aluSum[DATA_W-1] != Acc[DATA_W-1]);
        end
`ifdef BIP_SAT_EN
        // Overflow direction follows the sign of A: positive A can only overflow upward.
        if (aluOvf) begin
            aluRes = Acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            aluRes = aluSum;
        end
`else
        aluRes = aluSum;
`endif
    end

    // Accumulator source mux and write qualification (SelA=11 holds).
    always_comb begin
        accNext  = Acc;
        accWrite = wrAccEn && (selAEff != 2'b11);
        case (selAEff)
            2'b00:   accNext = memData;
            2'b01:   accNext = imm;
            2'b10:   accNext = aluRes;
            default: accNext = Acc;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state and stall; store wins over load when both are requested.
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = RdRam || WrRam;
                if (WrRam)      stateNext = WR_WAIT;
                else if (RdRam) stateNext = RD_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                stall = !ram_ack;
                if (ram_ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Memory request registers, control latches, accumulator and ovf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            selALat   <= 2'b00;
            selBLat   <= 1'b0;
            opLat     <= 1'b0;
            wrAccLat  <= 1'b0;
            Acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (WrRam) begin
                        ram_addr  <= Operand;
                        ram_wdata <= Acc;
                        ram_we    <= 1'b1;
                    end else if (RdRam) begin
                        ram_addr <= Operand;
                        ram_re   <= 1'b1;
                        selALat  <= SelA;
                        selBLat  <= SelB;
                        opLat    <= Op;
                        wrAccLat <= WrAcc;
                    end
                end
                RD_WAIT: if (ram_ack) ram_re <= 1'b0;
                WR_WAIT: if (ram_ack) ram_we <= 1'b0;
                default: ;
            endcase
            if (accWrite) begin
                Acc <= accNext;
                if (selAEff == 2'b10) ovf <= aluOvf;
            end
        end
    end

endmodule
